q2_sequencer: RTL
=================

// Module: q2_sequencer
// PURPOSE
//  Machine-cycle sequencer directly upstream of q2_control. Generates the state bits s0/ns0, s1/ns1, s2, s3
//  and the write strobe ws that q2_control decodes. Steps FETCH -> DEREF -> LOAD -> EXEC -> ALU -> FETCH.
//  Sequencing is gated by the front-panel run switch and a debounced single-step button.
// PARAMETERS
//  DEBOUNCE_W  16  width of step-button debounce counter; button must be stable 2**DEBOUNCE_W-1 clks
//  WS_CYCLES   1   clocks ws is held high per machine cycle (1..15)
// PORTS
//  clk       in   1  system clock, all state on rising edge
//  nreset    in   1  asynchronous, active-low reset
//  run       in   1  front-panel run switch, asynchronous, level
//  step_btn  in   1  front-panel single-step button, asynchronous, bouncing, active-high
//  deref     in   1  indirect bit of current instruction (dbus bit), sampled at end of FETCH
//  o2        in   1  opcode bit 2, sampled at end of FETCH and DEREF (o2=0 -> LOAD needed)
//  s2in      in   1  active-low ALU-cycle request from q2_control, sampled at end of EXEC only
//  s0, ns0   out  1  state bit 0 and its exact complement
//  s1, ns1   out  1  state bit 1 and its exact complement
//  s2        out  1  first ALU cycle
//  s3        out  1  second ALU cycle
//  ws        out  1  write strobe, high in write phase of each machine cycle
//  running   out  1  synchronized run level, as used by sequencer
//  cyc_end   out  1  one-clk pulse on the last clk of every machine cycle
// BEHAVIOUR
//  Reset (async, nreset=0): state=FETCH (s1s0=00, s2=s3=0, ns0=ns1=1); ws=0; running=0; cyc_end=0;
//   phase counter=0; synchronizers and debounce cleared. Outputs are registered; none glitch.
//  Encoding: FETCH s1s0=00, DEREF 01, LOAD 10, EXEC 11; ALU2 = EXEC code with s2=1; ALU3 = EXEC code with s3=1.
//   s2 and s3 are never both 1. ns0/ns1 always equal ~s0/~s1.
//  Machine cycle: 1 clk read phase (ws=0), then WS_CYCLES clks write phase (ws=1); cyc_end on last write clk.
//   Length = 1+WS_CYCLES clks. State advances on the clk after cyc_end. ws returns to 0 on that same edge.
//  Next state, evaluated at cyc_end:
//   FETCH: deref=1 -> DEREF; else o2=0 -> LOAD; else -> EXEC
//   DEREF: o2=0 -> LOAD; else -> EXEC
//   LOAD: -> EXEC
//   EXEC: s2in=0 -> ALU2; else -> FETCH
//   ALU2: -> ALU3;  ALU3: -> FETCH
//  Run/step: run and step_btn pass through 2-flop synchronizers. Debounce: step output changes only after
//   synced step stays stable for 2**DEBOUNCE_W-1 clks. step_pulse = 1-clk pulse on debounced rising edge.
//  Gating: a new machine cycle starts only when running=1, or when a step_pulse is latched as a step
//   request. If neither holds, the sequencer idles in the read phase of the current state (ws=0, no cyc_end).
//   A latched step runs exactly one machine cycle, then clears.
//  Boundary conditions:
//   - run drops mid-cycle: the current cycle completes, including its ws pulse; the sequencer then holds in
//     the next state.
//   - step_pulse while running=1: ignored and not latched.
//   - step_pulse while a stepped cycle is in progress: ignored.
//   - run rises while a step is latched: the step request clears and free-running begins.
//   - nreset mid-cycle: ws drops immediately and the sequencer returns to FETCH; a partial write is
//     tolerated by downstream logic.
//   - WS_CYCLES out of range: simulation $error.
// STRUCTURE
//  q2_pkg: localparams ST_FETCH=2'b00, ST_DEREF=2'b01, ST_LOAD=2'b10, ST_EXEC=2'b11; ALU phase codes.
//   Shared with q2_control benches.
//  Sub-module q2_debounce: synchronizer + counter + rising-edge pulse. Instantiated for step_btn.
//   run uses only the synchronizer (no debounce).
//  Top: phase counter (4 bit), state register (s1,s0,s2,s3), step-request flop, complement outputs.
// TESTING
//  1. Reset, run=1, deref=0, o2=1, s2in=1 -> s1s0 seq 00,11,00,...; each state 2 clks; ws=0,1 each state.
//  2. run=1, deref=1, o2=0 -> FETCH,DEREF,LOAD,EXEC,FETCH; check ns0/ns1 complement every clk.
//  3. o2=1, s2in=0 at EXEC end -> EXEC, then s2=1 one cycle, then s3=1 one cycle, then FETCH;
//     s2in changes in other states have no effect.
//  4. run=0; bounce step_btn for <2**DEBOUNCE_W clks (DEBOUNCE_W=4) -> no advance. Stable press ->
//     exactly one cycle with one ws pulse; second press during that cycle is ignored.
//  5. Drop run during ws=1 of LOAD -> EXEC reached, idles with ws=0, no cyc_end; re-assert run -> resumes.
//  6. Assert nreset low in write phase of EXEC (WS_CYCLES=3) -> ws=0 and FETCH asynchronously;
//     after release, first ws rises 1 clk after running=1.

Source files
------------

// File: rtl/q2_pkg.sv
// Shared state encodings for the Q2 machine-cycle sequencer and its control decoder.
// Also holds the next-state rule used at the end of every machine cycle.
package q2_pkg;

    localparam logic [1:0] ST_FETCH = 2'b00;
    localparam logic [1:0] ST_DEREF = 2'b01;
    localparam logic [1:0] ST_LOAD  = 2'b10;
    localparam logic [1:0] ST_EXEC  = 2'b11;

    // ALU phase codes, packed as {s3, s2}
    localparam logic [1:0] ALU_NONE = 2'b00;
    localparam logic [1:0] ALU_2    = 2'b01;
    localparam logic [1:0] ALU_3    = 2'b10;

    localparam int PHASE_W = 4;

    // Value layout is {s3, s2, s1, s0}, so the outputs come straight off the state flops.
    typedef enum logic [3:0] {
        SEQ_FETCH = {ALU_NONE, ST_FETCH},
        SEQ_DEREF = {ALU_NONE, ST_DEREF},
        SEQ_LOAD  = {ALU_NONE, ST_LOAD},
        SEQ_EXEC  = {ALU_NONE, ST_EXEC},
        SEQ_ALU2  = {ALU_2,    ST_EXEC},
        SEQ_ALU3  = {ALU_3,    ST_EXEC}
    } seq_state_e;

    function automatic seq_state_e next_state(
        input seq_state_e cur,
        input logic       deref,
        input logic       o2,
        input logic       s2in
    );
        case (cur)
            SEQ_FETCH: return deref ? SEQ_DEREF : (o2 ? SEQ_EXEC : SEQ_LOAD);
            SEQ_DEREF: return o2 ? SEQ_EXEC : SEQ_LOAD;
            SEQ_LOAD:  return SEQ_EXEC;
            SEQ_EXEC:  return s2in ? SEQ_FETCH : SEQ_ALU2;
            SEQ_ALU2:  return SEQ_ALU3;
            default:   return SEQ_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/q2_debounce.sv
// Two-flop synchronizer, stability counter and rising-edge pulse for a bouncing push button.
// The debounced level flips only after the synced input differs from it for 2**DEBOUNCE_W-1 clks.
module q2_debounce #(
    parameter int DEBOUNCE_W = 16
) (
    input  logic clk,
    input  logic nreset,
    input  logic i_async,
    output logic o_rise
);

    localparam logic [DEBOUNCE_W-1:0] CNT_LAST = {DEBOUNCE_W{1'b1}} - 1'b1;

    logic                  r_sync1;
    logic                  r_sync2;
    logic                  r_level;
    logic                  r_rise;
    logic [DEBOUNCE_W-1:0] r_cnt;

    // NOTE: every flop here uses <= so all of them sample pre-edge values; a blocking
    // assignment would collapse the two synchronizer stages into one.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync2;
                r_rise  <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/q2_sequencer.sv
// Machine-cycle sequencer feeding q2_control: FETCH/DEREF/LOAD/EXEC/ALU2/ALU3 with a write strobe,
// gated by a synchronized run switch and a debounced single-step button.
module q2_sequencer
    import q2_pkg::*;
#(
    parameter int DEBOUNCE_W = 16,
    parameter int WS_CYCLES  = 1
) (
    input  logic clk,
    input  logic nreset,
    input  logic run,
    input  logic step_btn,
    input  logic deref,
    input  logic o2,
    input  logic s2in,
    output logic s0,
    output logic ns0,
    output logic s1,
    output logic ns1,
    output logic s2,
    output logic s3,
    output logic ws,
    output logic running,
    output logic cyc_end
);

    if (WS_CYCLES < 1 || WS_CYCLES > 15) begin : g_ws_range
        $error("q2_sequencer: WS_CYCLES=%0d outside 1..15", WS_CYCLES);
    end

    localparam logic [PHASE_W-1:0] WS_LAST = PHASE_W'(WS_CYCLES);

    logic               r_run_sync1;
    logic               r_running;
    logic               w_step_rise;

    seq_state_e         r_state;
    seq_state_e         w_state_next;
    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] w_phase_next;
    logic               r_ws;
    logic               w_ws_next;
    logic               r_cyc_end;
    logic               w_cyc_end_next;
    logic               r_step_req;
    logic               w_step_req_next;
    logic               w_go;
    logic [3:0]         w_code;

    q2_debounce #(
        .DEBOUNCE_W (DEBOUNCE_W)
    ) u_step_debounce (
        .clk     (clk),
        .nreset  (nreset),
        .i_async (step_btn),
        .o_rise  (w_step_rise)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_run_sync1 <= 1'b0;
            r_running   <= 1'b0;
        end else begin
            r_run_sync1 <= run;
            r_running   <= r_run_sync1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state    <= SEQ_FETCH;
            r_phase    <= '0;
            r_ws       <= 1'b0;
            r_cyc_end  <= 1'b0;
            r_step_req <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_phase    <= w_phase_next;
            r_ws       <= w_ws_next;
            r_cyc_end  <= w_cyc_end_next;
            r_step_req <= w_step_req_next;
        end
    end

    assign w_go = r_running || r_step_req;

    // Phase 0 is the read phase and is where the sequencer parks when not allowed to run.
    // NOTE: every signal is given a default before the branches, so no path can leave one
    // unassigned and infer a latch.
    always_comb begin
        w_state_next    = r_state;
        w_phase_next    = r_phase;
        w_ws_next       = r_ws;
        w_cyc_end_next  = 1'b0;
        w_step_req_next = r_step_req;

        if (r_phase == '0) begin
            if (w_go) begin
                w_phase_next   = PHASE_W'(1);
                w_ws_next      = 1'b1;
                w_cyc_end_next = (WS_LAST == PHASE_W'(1));
            end
        end else if (r_phase == WS_LAST) begin
            w_phase_next = '0;
            w_ws_next    = 1'b0;
            w_state_next = next_state(r_state, deref, o2, s2in);
        end else begin
            w_phase_next   = r_phase + 1'b1;
            w_ws_next      = 1'b1;
            w_cyc_end_next = ((r_phase + 1'b1) == WS_LAST);
        end

        // A step is only accepted while parked; free-running always wins over a pending step.
        if (r_running) begin
            w_step_req_next = 1'b0;
        end else if (r_step_req && r_phase == WS_LAST) begin
            w_step_req_next = 1'b0;
        end else if (w_step_rise && !r_step_req && r_phase == '0) begin
            w_step_req_next = 1'b1;
        end
    end

    assign w_code  = r_state;
    assign s0      = w_code[0];
    assign s1      = w_code[1];
    assign s2      = w_code[2];
    assign s3      = w_code[3];
    assign ns0     = ~w_code[0];
    assign ns1     = ~w_code[1];
    assign ws      = r_ws;
    assign running = r_running;
    assign cyc_end = r_cyc_end;

endmodule
